// File: rtl/dma_channel_arbiter_pkg.sv
// Shared types for the two-channel DMA bus arbiter: FSM states and channel ids.
package dma_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DECIDE  = 2'd1,
    OWN     = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

  typedef enum logic {
    CH1 = 1'b0,
    CH2 = 1'b1
  } chan_id_t;

  function automatic chan_id_t other_chan(input chan_id_t c);
    return (c == CH1) ? CH2 : CH1;
  endfunction

endpackage

// File: rtl/dma_channel_arbiter_if.sv
// Channel request/completion inputs and grant outputs of the DMA channel arbiter.
interface dma_channel_arbiter_if;
  logic req1;
  logic req2;
  logic cpu_cfg_busy;
  logic burst_done1;
  logic burst_done2;
  logic chan_done1;
  logic chan_done2;
  logic arbitrate;
  logic grant1;
  logic grant2;
  logic give1;
  logic give2;
  logic valid_channels;

  modport master (
    output req1, req2, cpu_cfg_busy, burst_done1, burst_done2, chan_done1, chan_done2,
    input  arbitrate, grant1, grant2, give1, give2, valid_channels
  );

  modport slave (
    input  req1, req2, cpu_cfg_busy, burst_done1, burst_done2, chan_done1, chan_done2,
    output arbitrate, grant1, grant2, give1, give2, valid_channels
  );
endinterface

// File: rtl/dma_channel_arbiter_quantum.sv
// Counts owner bursts within one grant; at_max flags a full quantum of MAX_BURSTS.
module arb_quantum_counter #(
  parameter  int MAX_BURSTS = 4,
  localparam int CNT_W      = $clog2(MAX_BURSTS + 1)
) (
  input  logic AXI_aclk,
  input  logic AXI_aresetn,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // A burst landing on the clearing cycle starts the new quantum at one.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = inc ? CNT_W'(1) : '0;
    end else if (inc && (count_q != CNT_W'(MAX_BURSTS))) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge AXI_aclk or negedge AXI_aresetn) begin
    if (!AXI_aresetn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign at_max = (count_q == CNT_W'(MAX_BURSTS));

endmodule

// File: rtl/dma_channel_arbiter.sv
// Two-channel DMA bus arbiter: round-robin on ties, burst quantum, CPU-config preemption.
module dma_channel_arbiter
  import dma_arbiter_pkg::*;
#(
  parameter int MAX_BURSTS = 4
) (
  input logic                  AXI_aclk,
  input logic                  AXI_aresetn,
  dma_channel_arbiter_if.slave bus
);

  arb_state_t state_q, state_d;
  chan_id_t   owner_q, owner_d;
  chan_id_t   last_grant_q, last_grant_d;
  logic       preempt_q, preempt_d;
  logic       grant1_q, grant1_d;
  logic       grant2_q, grant2_d;
  logic       valid_q, valid_d;

  logic     any_req, can_start, own_bd, own_cd, other_req, leaving;
  logic     at_max, cnt_inc, cnt_clr;
  chan_id_t winner;

  assign any_req   = bus.req1 | bus.req2;
  assign can_start = any_req & ~bus.cpu_cfg_busy;
  assign own_bd    = (owner_q == CH1) ? bus.burst_done1 : bus.burst_done2;
  assign own_cd    = (owner_q == CH1) ? bus.chan_done1  : bus.chan_done2;
  assign other_req = (owner_q == CH1) ? bus.req2        : bus.req1;

  // On a tie the channel that did not own the bus last time wins.
  always_comb begin
    winner = other_chan(last_grant_q);
    if (bus.req1 && !bus.req2) winner = CH1;
    if (bus.req2 && !bus.req1) winner = CH2;
  end

  always_ff @(posedge AXI_aclk or negedge AXI_aresetn) begin
    if (!AXI_aresetn) begin
      state_q      <= IDLE;
      owner_q      <= CH1;
      last_grant_q <= CH2;
      preempt_q    <= 1'b0;
      grant1_q     <= 1'b0;
      grant2_q     <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      preempt_q    <= preempt_d;
      grant1_q     <= grant1_d;
      grant2_q     <= grant2_d;
      valid_q      <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    unique case (state_q)
      IDLE: begin
        if (can_start) state_d = DECIDE;
      end
      DECIDE: begin
        if (any_req) begin
          state_d = OWN;
          owner_d = winner;
        end else begin
          state_d = IDLE;
        end
      end
      OWN: begin
        // chan_done outranks a same-cycle burst_done; preemption waits for a burst boundary.
        if (own_cd)                       state_d = RELEASE;
        else if (own_bd && preempt_q)     state_d = RELEASE;
        else if (at_max && other_req)     state_d = RELEASE;
      end
      RELEASE: begin
        state_d = can_start ? DECIDE : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    leaving      = (state_q == OWN) && (state_d != OWN);
    grant1_d     = (state_d == OWN) && (owner_d == CH1);
    grant2_d     = (state_d == OWN) && (owner_d == CH2);
    last_grant_d = (state_q == RELEASE) ? owner_q : last_grant_q;
    preempt_d    = (state_q == OWN) && !leaving && (preempt_q || bus.cpu_cfg_busy);
    valid_d      = any_req;
    cnt_inc      = (state_q == OWN) && own_bd && !leaving;
    cnt_clr      = (state_q != OWN) || leaving || (at_max && !other_req);
  end

  arb_quantum_counter #(
    .MAX_BURSTS (MAX_BURSTS)
  ) u_quantum (
    .AXI_aclk    (AXI_aclk),
    .AXI_aresetn (AXI_aresetn),
    .inc         (cnt_inc),
    .clr         (cnt_clr),
    .at_max      (at_max)
  );

  assign bus.arbitrate      = (state_q == DECIDE) && any_req;
  assign bus.give1          = (state_q == RELEASE) && (owner_q == CH1);
  assign bus.give2          = (state_q == RELEASE) && (owner_q == CH2);
  assign bus.grant1         = grant1_q;
  assign bus.grant2         = grant2_q;
  assign bus.valid_channels = valid_q;

endmodule

// File: tb/tb_dma_channel_arbiter.sv
// Directed, table-driven bench for dma_channel_arbiter (MAX_BURSTS=4 and MAX_BURSTS=2).
module tb_dma_channel_arbiter;

  logic clk = 1'b0;
  logic rstn_a = 1'b0;
  logic rstn_b = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  dma_channel_arbiter_if ifa ();
  dma_channel_arbiter_if ifb ();

  dma_channel_arbiter #(.MAX_BURSTS(4)) dut4 (
    .AXI_aclk    (clk),
    .AXI_aresetn (rstn_a),
    .bus         (ifa)
  );

  dma_channel_arbiter #(.MAX_BURSTS(2)) dut2 (
    .AXI_aclk    (clk),
    .AXI_aresetn (rstn_b),
    .bus         (ifb)
  );

  // input bits: {rst, r1, r2, busy, bd1, bd2, cd1, cd2}
  localparam logic [7:0] RST = 8'b1000_0000, R1 = 8'b0100_0000, R2 = 8'b0010_0000,
                         BZ  = 8'b0001_0000, BD1 = 8'b0000_1000, BD2 = 8'b0000_0100,
                         CD1 = 8'b0000_0010, CD2 = 8'b0000_0001, NONE = 8'b0;
  // expected bits: {arbitrate, grant1, grant2, give1, give2, valid_channels}
  localparam logic [5:0] ARB = 6'b100000, G1 = 6'b010000, G2 = 6'b001000,
                         GV1 = 6'b000100, GV2 = 6'b000010, VAL = 6'b000001, ZERO = 6'b0;

  typedef struct packed {
    logic [7:0] in;
    logic [5:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive_a(input logic [7:0] in);
    rstn_a           = ~in[7];
    ifa.req1         = in[6];
    ifa.req2         = in[5];
    ifa.cpu_cfg_busy = in[4];
    ifa.burst_done1  = in[3];
    ifa.burst_done2  = in[2];
    ifa.chan_done1   = in[1];
    ifa.chan_done2   = in[0];
  endtask

  task automatic drive_b(input logic r2, input logic bd2);
    ifb.req1         = 1'b0;
    ifb.req2         = r2;
    ifb.cpu_cfg_busy = 1'b0;
    ifb.burst_done1  = 1'b0;
    ifb.burst_done2  = bd2;
    ifb.chan_done1   = 1'b0;
    ifb.chan_done2   = 1'b0;
  endtask

  // Grants and gives of each instance must stay mutually exclusive every cycle.
  always @(negedge clk) begin
    chk("excl_grant_a", 32'(ifa.grant1 & ifa.grant2), 32'd0);
    chk("excl_give_a",  32'(ifa.give1 & ifa.give2),   32'd0);
    chk("excl_grant_b", 32'(ifb.grant1 & ifb.grant2), 32'd0);
  end

  initial begin
    logic [5:0] act;
    drive_a(RST);
    drive_b(1'b0, 1'b0);

    // Single requester, then chan_done
    tbl.push_back('{RST, ZERO});
    tbl.push_back('{R1, ZERO});
    tbl.push_back('{R1, ARB | VAL});
    tbl.push_back('{R1, G1 | VAL});
    tbl.push_back('{R1 | CD1, G1 | VAL});
    tbl.push_back('{NONE, GV1 | VAL});
    tbl.push_back('{NONE, ZERO});
    // Tie from reset: CH1 first, quantum of 4, then CH2, then CH1 again
    tbl.push_back('{RST, ZERO});
    tbl.push_back('{R1 | R2, ZERO});
    tbl.push_back('{R1 | R2, ARB | VAL});
    tbl.push_back('{R1 | R2, G1 | VAL});
    for (int k = 0; k < 4; k++) tbl.push_back('{R1 | R2 | BD1, G1 | VAL});
    tbl.push_back('{R1 | R2, G1 | VAL});
    tbl.push_back('{R1 | R2, GV1 | VAL});
    tbl.push_back('{R1 | R2, ARB | VAL});
    tbl.push_back('{R1 | R2, G2 | VAL});
    for (int k = 0; k < 4; k++) tbl.push_back('{R1 | R2 | BD2, G2 | VAL});
    tbl.push_back('{R1 | R2, G2 | VAL});
    tbl.push_back('{R1 | R2, GV2 | VAL});
    tbl.push_back('{R1 | R2, ARB | VAL});
    tbl.push_back('{R1 | R2, G1 | VAL});
    // Reset mid-OWN drops the grant at once; CH1 then wins the first tie
    tbl.push_back('{RST, ZERO});
    tbl.push_back('{R1 | R2, ZERO});
    tbl.push_back('{R1 | R2, ARB | VAL});
    tbl.push_back('{R1 | R2, G1 | VAL});
    // CPU config busy: hold until next owner burst, then no DECIDE while busy
    tbl.push_back('{R1 | R2 | BZ, G1 | VAL});
    tbl.push_back('{R1 | R2 | BZ, G1 | VAL});
    tbl.push_back('{R1 | R2 | BZ | BD1, G1 | VAL});
    tbl.push_back('{R1 | R2 | BZ, GV1 | VAL});
    tbl.push_back('{R1 | R2 | BZ, VAL});
    tbl.push_back('{R1 | R2 | BZ, VAL});
    tbl.push_back('{R1 | R2, VAL});
    tbl.push_back('{R1 | R2, ARB | VAL});
    tbl.push_back('{R1 | R2, G2 | VAL});
    tbl.push_back('{R1 | R2 | CD2, G2 | VAL});
    tbl.push_back('{R1, GV2 | VAL});
    tbl.push_back('{R1, ARB | VAL});
    tbl.push_back('{R1, G1 | VAL});
    tbl.push_back('{NONE, G1 | VAL});

    foreach (tbl[i]) begin
      @(negedge clk);
      drive_a(tbl[i].in);
      #1;
      act = {ifa.arbitrate, ifa.grant1, ifa.grant2, ifa.give1, ifa.give2, ifa.valid_channels};
      chk($sformatf("row%0d arbitrate", i), 32'(act[5]), 32'(tbl[i].exp[5]));
      chk($sformatf("row%0d grant1", i),    32'(act[4]), 32'(tbl[i].exp[4]));
      chk($sformatf("row%0d grant2", i),    32'(act[3]), 32'(tbl[i].exp[3]));
      chk($sformatf("row%0d give1", i),     32'(act[2]), 32'(tbl[i].exp[2]));
      chk($sformatf("row%0d give2", i),     32'(act[1]), 32'(tbl[i].exp[1]));
      chk($sformatf("row%0d valid", i),     32'(act[0]), 32'(tbl[i].exp[0]));
    end

    // chan_done1 with burst_done1 at count 3 (MAX_BURSTS=4)
    @(negedge clk); drive_a(RST);
    @(negedge clk); drive_a(R1);
    @(negedge clk); drive_a(R1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); drive_a(R1 | BD1);
    end
    @(negedge clk); drive_a(R1); #1;
    chk("cd_bd count before", 32'(dut4.u_quantum.count_q), 32'd3);
    chk("cd_bd grant1 before", 32'(ifa.grant1), 32'd1);
    @(negedge clk); drive_a(R1 | BD1 | CD1); #1;
    chk("cd_bd grant1 same cycle", 32'(ifa.grant1), 32'd1);
    @(negedge clk); drive_a(NONE); #1;
    chk("cd_bd give1", 32'(ifa.give1), 32'd1);
    chk("cd_bd grant1 after", 32'(ifa.grant1), 32'd0);
    chk("cd_bd count after", 32'(dut4.u_quantum.count_q), 32'd0);

    // CH2 alone, MAX_BURSTS=2: quantum wraps, grant never released
    @(negedge clk); rstn_b = 1'b1; drive_b(1'b1, 1'b0);
    @(negedge clk); drive_b(1'b1, 1'b0);
    @(negedge clk); drive_b(1'b1, 1'b0); #1;
    chk("wrap grant2 start", 32'(ifb.grant2), 32'd1);
    for (int p = 0; p < 5; p++) begin
      @(negedge clk); drive_b(1'b1, 1'b1); #1;
      chk($sformatf("wrap p%0d count", p), 32'(dut2.u_quantum.count_q), 32'(p % 2));
      chk($sformatf("wrap p%0d grant2", p), 32'(ifb.grant2), 32'd1);
      @(negedge clk); drive_b(1'b1, 1'b0); #1;
      chk($sformatf("wrap g%0d count", p), 32'(dut2.u_quantum.count_q), 32'((p % 2) + 1));
      chk($sformatf("wrap g%0d give2", p), 32'(ifb.give2), 32'd0);
      chk($sformatf("wrap g%0d arbitrate", p), 32'(ifb.arbitrate), 32'd0);
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
